// File: rtl/exu_stage.sv
// Execute stage: applies the decoded ALU op, forms the LSU-bound bus and
// buffers it through a two-entry (main + skid) valid/ready stage. Jumps and
// taken branches raise a one-cycle front-end redirect pulse.
module exu_stage #(
  parameter int DEU_EXU_BUS_WIDTH = 196,
  parameter int EXU_LSU_BUS_WIDTH = 127
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DEU_EXU_BUS_WIDTH-1:0] deu_exu_bus_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [EXU_LSU_BUS_WIDTH-1:0] exu_lsu_bus_o,
  output logic                         redirect_valid_o,
  output logic [31:0]                  redirect_pc_o
);

  // ALU operation encodings carried in the alu_op field
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_SRA = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  // Decoded input fields
  logic        in_excp_flush;
  logic        in_xret_flush;
  logic        in_break;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [31:0] in_rs2_value;
  logic [2:0]  in_alu_op;
  logic        in_res_from_mem;
  logic        in_gr_we;
  logic        in_csr_we;
  logic [3:0]  in_mem_re;
  logic [3:0]  in_mem_we;
  logic [4:0]  in_rd;
  logic        in_jmp_flag;
  logic [11:0] in_csr_addr;
  logic [31:0] in_csr_wdata;
  logic        in_res_from_pre;
  logic [31:0] in_final_result;

  assign in_excp_flush   = deu_exu_bus_i[195];
  assign in_xret_flush   = deu_exu_bus_i[194];
  assign in_break        = deu_exu_bus_i[193];
  assign in_src1         = deu_exu_bus_i[192:161];
  assign in_src2         = deu_exu_bus_i[160:129];
  assign in_rs2_value    = deu_exu_bus_i[128:97];
  assign in_alu_op       = deu_exu_bus_i[96:94];
  assign in_res_from_mem = deu_exu_bus_i[93];
  assign in_gr_we        = deu_exu_bus_i[92];
  assign in_csr_we       = deu_exu_bus_i[91];
  assign in_mem_re       = deu_exu_bus_i[90:87];
  assign in_mem_we       = deu_exu_bus_i[86:83];
  assign in_rd           = deu_exu_bus_i[82:78];
  assign in_jmp_flag     = deu_exu_bus_i[77];
  assign in_csr_addr     = deu_exu_bus_i[76:65];
  assign in_csr_wdata    = deu_exu_bus_i[64:33];
  assign in_res_from_pre = deu_exu_bus_i[32];
  assign in_final_result = deu_exu_bus_i[31:0];

  // The 127-bit LSU bus has no slot for csr_wdata; it is reduced into a
  // named sink so that dropping it is a visible, deliberate choice.
  logic unused_csr_wdata;
  assign unused_csr_wdata = ^in_csr_wdata;

  // Storage state
  logic                         main_valid;
  logic                         skid_valid;
  logic [EXU_LSU_BUS_WIDTH-1:0] main_bus;
  logic [EXU_LSU_BUS_WIDTH-1:0] skid_bus;
  logic                         redirect_valid_q;
  logic [31:0]                  redirect_pc_q;

  // Datapath intermediates
  logic [31:0]                  alu_res;
  logic [4:0]                   shamt;
  logic [31:0]                  result;
  logic [EXU_LSU_BUS_WIDTH-1:0] out_word;

  // Handshake and steering controls
  logic accept;
  logic keep;
  logic drain;
  logic main_free;
  logic redirect_fire;
  logic main_valid_n;
  logic skid_valid_n;
  logic main_from_in;
  logic main_from_skid;
  logic skid_from_in;

  assign shamt = in_src2[4:0];

  // ALU: all arithmetic wraps mod 2^32, sra keeps the sign of src1
  always_comb begin
    alu_res = '0;
    case (in_alu_op)
      ALU_ADD: alu_res = in_src1 + in_src2;
      ALU_SUB: alu_res = in_src1 - in_src2;
      ALU_SLL: alu_res = in_src1 << shamt;
      ALU_SRA: alu_res = $unsigned($signed(in_src1) >>> shamt);
      ALU_SRL: alu_res = in_src1 >> shamt;
      ALU_AND: alu_res = in_src1 & in_src2;
      ALU_OR:  alu_res = in_src1 | in_src2;
      ALU_XOR: alu_res = in_src1 ^ in_src2;
      default: alu_res = '0;
    endcase
  end

  // Writeback selection and packing of the outgoing bus
  always_comb begin
    result   = in_res_from_pre ? in_final_result : alu_res;
    out_word = {in_excp_flush, in_xret_flush, in_break,
                in_res_from_mem, in_gr_we, in_csr_we,
                in_mem_re, in_mem_we, in_rd, in_csr_addr,
                result, alu_res, in_rs2_value};
  end

  // Ready is a pure function of the skid register, so it never depends
  // combinationally on out_ready_i.
  assign in_ready_o = ~skid_valid;

  // Inputs taken while a redirect pulse is out, or in a flush cycle, are
  // wrong-path: the handshake completes but nothing is stored.
  assign accept        = in_valid_i & in_ready_o;
  assign keep          = accept & ~redirect_valid_q & ~flush_i;
  assign drain         = main_valid & out_ready_i;
  assign main_free     = ~main_valid | drain;
  assign redirect_fire = keep & in_jmp_flag;

  // Steering: main refills from skid first so order stays FIFO; a new
  // input lands in main only when nothing older is waiting.
  always_comb begin
    main_valid_n   = main_valid;
    skid_valid_n   = skid_valid;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    if (main_free) begin
      if (skid_valid) begin
        main_from_skid = 1'b1;
        main_valid_n   = 1'b1;
        skid_from_in   = keep;
        skid_valid_n   = keep;
      end else begin
        main_from_in = keep;
        main_valid_n = keep;
      end
    end else if (keep) begin
      skid_from_in = 1'b1;
      skid_valid_n = 1'b1;
    end
  end

  // Occupancy and redirect flags; flush kills everything held
  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid       <= 1'b0;
      skid_valid       <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else if (flush_i) begin
      main_valid       <= 1'b0;
      skid_valid       <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else begin
      main_valid       <= main_valid_n;
      skid_valid       <= skid_valid_n;
      redirect_valid_q <= redirect_fire;
    end
  end

  // Payload registers load only on a steering event and hold otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      main_bus <= '0;
      skid_bus <= '0;
    end else begin
      if (main_from_skid) begin
        main_bus <= skid_bus;
      end else if (main_from_in) begin
        main_bus <= out_word;
      end
      if (skid_from_in) begin
        skid_bus <= out_word;
      end
    end
  end

  // Redirect target is captured at accept with bit 0 cleared
  always_ff @(posedge clock) begin
    if (reset) begin
      redirect_pc_q <= '0;
    end else if (redirect_fire) begin
      redirect_pc_q <= alu_res & ~32'h1;
    end
  end

  // Output valid is masked in the reset cycle so no transfer completes
  // there even though the occupancy flag only clears at the edge.
  assign out_valid_o      = main_valid & ~reset;
  assign exu_lsu_bus_o    = main_bus;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

  // The skid entry is only ever occupied behind a held main entry
  a_skid_behind_main: assert property (
    @(posedge clock) disable iff (reset) skid_valid |-> main_valid);

  // A stalled output must not change until it is taken or flushed
  a_stall_stable: assert property (
    @(posedge clock) disable iff (reset)
    (out_valid_o && !out_ready_i && !flush_i) |=>
    (out_valid_o && $stable(exu_lsu_bus_o)));

endmodule

// File: tb/tb_exu_stage.sv
// Scoreboard bench for exu_stage: directed vectors push expected LSU words
// and redirect targets into queues; a monitor pops and compares them.
module tb_exu_stage;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [195:0] deu_exu_bus_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [126:0] exu_lsu_bus_o;
  logic         redirect_valid_o;
  logic [31:0]  redirect_pc_o;

  typedef struct packed {
    logic        excp;
    logic        xret;
    logic        brk;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rs2;
    logic [2:0]  alu_op;
    logic        res_from_mem;
    logic        gr_we;
    logic        csr_we;
    logic [3:0]  mem_re;
    logic [3:0]  mem_we;
    logic [4:0]  rd;
    logic        jmp;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        res_from_pre;
    logic [31:0] final_result;
  } in_t;

  int checks = 0;
  int failures = 0;
  logic [126:0] exp_q[$];
  logic [31:0]  rpc_q[$];

  exu_stage dut (
    .clock            (clock),
    .reset            (reset),
    .flush_i          (flush_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .deu_exu_bus_i    (deu_exu_bus_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .exu_lsu_bus_o    (exu_lsu_bus_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [126:0] expectedBus(input in_t v, input logic [31:0] res, input logic [31:0] addr);
    return {v.excp, v.xret, v.brk, v.res_from_mem, v.gr_we, v.csr_we,
            v.mem_re, v.mem_we, v.rd, v.csr_addr, res, addr, v.rs2};
  endfunction

  function automatic in_t mkVec(input logic [31:0] s1, input logic [31:0] s2, input logic [2:0] op);
    in_t v;
    v        = '0;
    v.src1   = s1;
    v.src2   = s2;
    v.alu_op = op;
    v.gr_we  = 1'b1;
    return v;
  endfunction

  // Present one vector, wait (bounded) for acceptance, record expectations
  task automatic applyStimulus(input in_t v, input logic [31:0] exp_res, input logic [31:0] exp_addr,
                               input logic [31:0] exp_rpc, input bit exp_out, input bit exp_rdr);
    bit got;
    got           = 1'b0;
    in_valid_i    = 1'b1;
    deu_exu_bus_i = v;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (in_ready_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1 within 50 cycles");
    end else begin
      if (exp_out) exp_q.push_back(expectedBus(v, exp_res, exp_addr));
      if (exp_rdr) rpc_q.push_back(exp_rpc);
      @(posedge clock);
      #1;
    end
    in_valid_i = 1'b0;
  endtask

  // Monitor: compares transfers and redirect pulses, and checks stall hold
  logic [126:0] held_bus;
  bit           prev_stall = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_hold_valid", 128'(out_valid_o), 128'(1));
        checkOutput("stall_hold_bus", 128'(exu_lsu_bus_o), 128'(held_bus));
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output: got %0h with empty scoreboard", exu_lsu_bus_o);
        end else begin
          checkOutput("out_bus", 128'(exu_lsu_bus_o), 128'(exp_q.pop_front()));
        end
      end
      if (redirect_valid_o) begin
        if (rpc_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_redirect: got pc %0h with none expected", redirect_pc_o);
        end else begin
          checkOutput("redirect_pc", 128'(redirect_pc_o), 128'(rpc_q.pop_front()));
        end
      end
      prev_stall = out_valid_o && !out_ready_i && !flush_i;
      held_bus   = exu_lsu_bus_o;
    end
  end

  in_t v, a, b, c;

  initial begin
    reset         = 1'b1;
    flush_i       = 1'b0;
    in_valid_i    = 1'b0;
    out_ready_i   = 1'b0;
    deu_exu_bus_i = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    $display("[TB] reset state");
    @(negedge clock);
    checkOutput("rst_out_valid", 128'(out_valid_o), 128'(0));
    checkOutput("rst_in_ready", 128'(in_ready_o), 128'(1));
    checkOutput("rst_redirect_valid", 128'(redirect_valid_o), 128'(0));
    checkOutput("rst_redirect_pc", 128'(redirect_pc_o), 128'(0));
    checkOutput("rst_bus", 128'(exu_lsu_bus_o), 128'(0));
    @(posedge clock);
    #1;

    $display("[TB] ALU and datapath vectors");
    out_ready_i = 1'b1;
    v = mkVec(32'd5, 32'd7, 3'b000); v.rd = 5'd3;
    applyStimulus(v, 32'd12, 32'd12, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("add_latency_valid", 128'(out_valid_o), 128'(1));
    @(posedge clock);
    #1;
    v = mkVec(32'h8000_0000, 32'h24, 3'b011);
    applyStimulus(v, 32'hF800_0000, 32'hF800_0000, 32'h0, 1'b1, 1'b0);
    v = mkVec(32'd3, 32'd5, 3'b001);
    applyStimulus(v, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0);
    v = mkVec(32'h1, 32'h1F, 3'b010);
    applyStimulus(v, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
    v = mkVec(32'h8000_0000, 32'h21, 3'b100);
    applyStimulus(v, 32'h4000_0000, 32'h4000_0000, 32'h0, 1'b1, 1'b0);
    v = mkVec(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101);
    applyStimulus(v, 32'hF000_F000, 32'hF000_F000, 32'h0, 1'b1, 1'b0);
    v = mkVec(32'hF0F0_F0F0, 32'h0F0F_0000, 3'b110);
    applyStimulus(v, 32'hFFFF_F0F0, 32'hFFFF_F0F0, 32'h0, 1'b1, 1'b0);
    v = mkVec(32'hFFFF_0000, 32'h0F0F_0F0F, 3'b111);
    applyStimulus(v, 32'hF0F0_0F0F, 32'hF0F0_0F0F, 32'h0, 1'b1, 1'b0);
    v = mkVec(32'hFFFF_FFFF, 32'h2, 3'b000);
    applyStimulus(v, 32'h1, 32'h1, 32'h0, 1'b1, 1'b0);
    v = mkVec(32'h1000, 32'h8, 3'b000); v.mem_we = 4'b1111; v.rs2 = 32'hDEAD_BEEF;
    applyStimulus(v, 32'h1008, 32'h1008, 32'h0, 1'b1, 1'b0);
    v = mkVec(32'h0000_FFFF, 32'h0000_0FF0, 3'b101);
    v.excp = 1'b1; v.brk = 1'b1; v.res_from_mem = 1'b1; v.gr_we = 1'b0; v.csr_we = 1'b1;
    v.mem_re = 4'hA; v.mem_we = 4'h5; v.rd = 5'd31; v.csr_addr = 12'h305;
    v.csr_wdata = 32'h1234; v.rs2 = 32'hCAFE_F00D;
    applyStimulus(v, 32'h0000_0FF0, 32'h0000_0FF0, 32'h0, 1'b1, 1'b0);
    v = mkVec(32'h1, 32'h1, 3'b000); v.xret = 1'b1; v.res_from_pre = 1'b1; v.final_result = 32'h1234_5678;
    applyStimulus(v, 32'h1234_5678, 32'h2, 32'h0, 1'b1, 1'b0);

    $display("[TB] jalr redirect and wrong-path drop");
    v = mkVec(32'h8000_0101, 32'h0, 3'b000); v.jmp = 1'b1; v.res_from_pre = 1'b1; v.final_result = 32'h8000_0014;
    applyStimulus(v, 32'h8000_0014, 32'h8000_0101, 32'h8000_0100, 1'b1, 1'b1);
    v = mkVec(32'h55, 32'h1, 3'b000); v.jmp = 1'b1;
    applyStimulus(v, 32'h56, 32'h56, 32'h56, 1'b0, 1'b0);
    v = mkVec(32'd100, 32'd1, 3'b000);
    applyStimulus(v, 32'd101, 32'd101, 32'h0, 1'b1, 1'b0);
    repeat (3) @(posedge clock);
    #1;

    $display("[TB] backpressure A,B,C");
    out_ready_i = 1'b0;
    a = mkVec(32'h1, 32'h1, 3'b000);
    b = mkVec(32'hF, 32'h3, 3'b001);
    c = mkVec(32'h6, 32'h3, 3'b010);
    applyStimulus(a, 32'h2, 32'h2, 32'h0, 1'b1, 1'b0);
    applyStimulus(b, 32'hC, 32'hC, 32'h0, 1'b1, 1'b0);
    fork
      applyStimulus(c, 32'h30, 32'h30, 32'h0, 1'b1, 1'b0);
      begin
        @(negedge clock);
        checkOutput("bp_in_ready", 128'(in_ready_o), 128'(0));
        checkOutput("bp_out_valid", 128'(out_valid_o), 128'(1));
        checkOutput("bp_head_is_A", 128'(exu_lsu_bus_o), 128'(expectedBus(a, 32'h2, 32'h2)));
        repeat (3) @(posedge clock);
        #1 out_ready_i = 1'b1;
      end
    join
    repeat (5) @(posedge clock);
    #1;

    $display("[TB] flush with main+skid full and jump in flight");
    out_ready_i = 1'b0;
    v = mkVec(32'd10, 32'd20, 3'b000);
    applyStimulus(v, 32'd30, 32'd30, 32'h0, 1'b1, 1'b0);
    v = mkVec(32'h2000, 32'h11, 3'b000); v.jmp = 1'b1;
    applyStimulus(v, 32'h2011, 32'h2011, 32'h2010, 1'b1, 1'b1);
    flush_i = 1'b1;
    @(posedge clock);
    #1 flush_i = 1'b0;
    exp_q.delete();
    @(negedge clock);
    checkOutput("flush_out_valid", 128'(out_valid_o), 128'(0));
    checkOutput("flush_in_ready", 128'(in_ready_o), 128'(1));
    checkOutput("flush_redirect_valid", 128'(redirect_valid_o), 128'(0));
    out_ready_i = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    flush_i = 1'b1;
    v = mkVec(32'h7, 32'h7, 3'b000); v.jmp = 1'b1;
    applyStimulus(v, 32'hE, 32'hE, 32'hE, 1'b0, 1'b0);
    flush_i = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    $display("[TB] reset held one cycle mid-stall");
    out_ready_i = 1'b0;
    v = mkVec(32'h1, 32'h2, 3'b000);
    applyStimulus(v, 32'h3, 32'h3, 32'h0, 1'b1, 1'b0);
    v = mkVec(32'h40, 32'h4, 3'b000); v.jmp = 1'b1;
    applyStimulus(v, 32'h44, 32'h44, 32'h44, 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    checkOutput("rst2_out_valid", 128'(out_valid_o), 128'(0));
    checkOutput("rst2_in_ready", 128'(in_ready_o), 128'(1));
    checkOutput("rst2_redirect_valid", 128'(redirect_valid_o), 128'(0));
    checkOutput("rst2_redirect_pc", 128'(redirect_pc_o), 128'(0));
    checkOutput("rst2_bus", 128'(exu_lsu_bus_o), 128'(0));
    out_ready_i = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    v = mkVec(32'h123, 32'h4, 3'b100);
    applyStimulus(v, 32'h12, 32'h12, 32'h0, 1'b1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && rpc_q.size() == 0) break;
    end
    checkOutput("drain_out_queue", 128'(exp_q.size()), 128'(0));
    checkOutput("drain_redirect_queue", 128'(rpc_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
